// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types for the core memory interface.
//   request_t : one beat on the request or response channel
//               {vld, func, addr, data, access_id}
//   MEM_READ / MEM_WRITE : func encodings. Any other func value is serviced
//               as a read by the responder.
// -----------------------------------------------------------------------------
package mem_pkg;

   localparam int REQ_DATA_W = 64;

   localparam logic [1:0] MEM_READ  = 2'd0;
   localparam logic [1:0] MEM_WRITE = 2'd1;

   typedef struct packed {
      logic                  vld;
      logic [1:0]            func;
      logic [31:0]           addr;
      logic [REQ_DATA_W-1:0] data;
      logic [7:0]            access_id;
   } request_t;

endpackage

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Bundles the core <-> memory handshake.
//   mem_req : request from the core (core drives)
//   mem_rsp : response to the core (memory drives)
//   busy    : back-pressure hint from memory to the upstream arbiter
// Modports:
//   master : core side
//   slave  : memory side
// -----------------------------------------------------------------------------
interface mem_responder_if;
   import mem_pkg::*;

   request_t mem_req;
   request_t mem_rsp;
   logic     busy;

   modport master (output mem_req, input mem_rsp, input busy);
   modport slave  (input mem_req, output mem_rsp, output busy);

endinterface

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side endpoint of the core memory interface. Requests are queued in a
// FIFO and serviced in order against a word-addressed array. Exactly one
// response per accepted request comes back MEM_LATENCY cycles after it is
// dequeued, with access_id echoed unchanged. After reset the array is swept to
// zero before any request is serviced.
// Ports:
//   clk       : clock
//   reset     : synchronous active-low reset
//   bus       : slave modport (mem_req in, mem_rsp out, busy out)
//   overflow  : sticky, a request arrived while the FIFO was full
//   init_done : array clear sweep complete
// -----------------------------------------------------------------------------
module mem_responder
   import mem_pkg::*;
#(
   parameter int MEM_DEPTH      = 1024,
   parameter int DATA_WIDTH     = 64,
   parameter int ADDR_LSB       = 3,
   parameter int REQ_FIFO_DEPTH = 8,
   parameter int MEM_LATENCY    = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   mem_responder_if.slave         bus,
   output logic                   overflow,
   output logic                   init_done
);

   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam int PTR_W = $clog2(REQ_FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]            state;
   logic [IDX_W-1:0]      init_idx;

   request_t              fifo_q [REQ_FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  full;
   logic                  enq;
   logic                  deq;

   request_t              head;
   logic [IDX_W-1:0]      head_idx;
   logic                  head_write;

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
   logic                  mem_we;
   logic [IDX_W-1:0]      mem_widx;
   logic [DATA_WIDTH-1:0] mem_wdata;

   request_t              rsp_pipe [MEM_LATENCY];
   request_t              stage_in;

   // Full is judged on the pre-cycle count, so a request arriving on a full
   // FIFO is dropped even if a dequeue frees a slot in the same cycle.
   assign full       = (count == CNT_W'(REQ_FIFO_DEPTH));
   assign enq        = bus.mem_req.vld && !full;
   assign deq        = (state == ST_RUN) && (count != '0);

   assign head       = fifo_q[rd_ptr];
   // Upper address bits are ignored, so out-of-range addresses wrap.
   assign head_idx   = head.addr[ADDR_LSB +: IDX_W];
   assign head_write = (head.func == MEM_WRITE);

   // The 2-entry margin covers the core's registered request stage.
   assign bus.busy   = (state == ST_INIT) || (count >= CNT_W'(REQ_FIFO_DEPTH - 2));

   // Control: FSM, sweep index, FIFO pointers, sticky overflow
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_INIT;
         init_idx  <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         init_done <= 1'b0;
      end else begin
         if (state == ST_INIT) begin
            init_idx <= init_idx + 1'b1;
            if (init_idx == IDX_W'(MEM_DEPTH - 1)) begin
               state     <= ST_RUN;
               init_done <= 1'b1;
            end
         end
         if (enq) wr_ptr <= wr_ptr + 1'b1;
         if (deq) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(enq) - CNT_W'(deq);
         if (bus.mem_req.vld && full) overflow <= 1'b1;
      end
   end

   // Request storage: whole struct captured on accept
   always_ff @(posedge clk) begin
      if (enq) fifo_q[wr_ptr] <= bus.mem_req;
   end

   // Single write port shared by the clear sweep and dequeued writes; the two
   // never coincide because nothing is dequeued during INIT.
   always_comb begin
      mem_we    = 1'b0;
      mem_widx  = head_idx;
      mem_wdata = head.data[DATA_WIDTH-1:0];
      if (state == ST_INIT) begin
         mem_we    = reset;
         mem_widx  = init_idx;
         mem_wdata = '0;
      end else if (deq && head_write) begin
         mem_we    = reset;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_widx] <= mem_wdata;
   end

   // Response for the dequeued request: reads sample the array in the dequeue
   // cycle, so a write dequeued one cycle earlier is already visible.
   always_comb begin
      stage_in     = head;
      stage_in.vld = deq;
      if (!head_write) stage_in.data = REQ_DATA_W'(mem_q[head_idx]);
   end

   // Response pipe: MEM_LATENCY register stages, last stage drives mem_rsp
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < MEM_LATENCY; i++) rsp_pipe[i].vld <= 1'b0;
         rsp_pipe[MEM_LATENCY-1] <= '0;
      end else begin
         rsp_pipe[0] <= stage_in;
         for (int i = 1; i < MEM_LATENCY; i++) rsp_pipe[i] <= rsp_pipe[i-1];
      end
   end

   assign bus.mem_rsp = rsp_pipe[MEM_LATENCY-1];

endmodule
